// File: rtl/lifo_stack_if.sv
// Handshake/status bundle for lifo_stack; the hwm signal exists only when LIFO_HWM_EN is defined.
interface lifo_stack_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
    logic              push;
    logic              pop;
    logic              clr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
`ifdef LIFO_HWM_EN
    logic [ADDR_W:0]   hwm;
`endif

    modport master (
`ifdef LIFO_HWM_EN
        input  hwm,
`endif
        output push, pop, clr, din,
        input  dout, dout_valid, count, full, empty, overflow, underflow
    );

    modport slave (
`ifdef LIFO_HWM_EN
        output hwm,
`endif
        input  push, pop, clr, din,
        output dout, dout_valid, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered pop data, sticky error flags and push+pop replace-top.
// Optional high-water mark output enabled by defining LIFO_HWM_EN.
module lifo_stack #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    lifo_stack_if.slave   bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   count_q, count_n;
    logic [DATA_W-1:0] dout_q, dout_n;
    logic              dv_q, dv_n;
    logic              ovf_q, ovf_n;
    logic              unf_q, unf_n;
    logic              full, empty;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   count_m1;
    logic [ADDR_W-1:0] top_addr;

    assign full     = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count_m1 = count_q - 1'b1;
    assign top_addr = count_m1[ADDR_W-1:0];

    always_comb begin
        count_n = count_q;
        dout_n  = dout_q;
        dv_n    = 1'b0;
        ovf_n   = ovf_q;
        unf_n   = unf_q;
        wr_en   = 1'b0;
        wr_addr = count_q[ADDR_W-1:0];
        if (bus.clr) begin
            count_n = '0;
            ovf_n   = 1'b0;
            unf_n   = 1'b0;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (full) ovf_n = 1'b1;
                    else begin
                        wr_en   = 1'b1;
                        count_n = count_q + 1'b1;
                    end
                end
                2'b01: begin
                    if (empty) unf_n = 1'b1;
                    else begin
                        dout_n  = mem[top_addr];
                        dv_n    = 1'b1;
                        count_n = count_m1;
                    end
                end
                2'b11: begin
                    dv_n = 1'b1;
                    // Replace-top reads the old top before the same-edge write lands.
                    if (empty) dout_n = bus.din;
                    else begin
                        dout_n  = mem[top_addr];
                        wr_en   = 1'b1;
                        wr_addr = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_n;
            dout_q  <= dout_n;
            dv_q    <= dv_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.din;
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;

`ifdef LIFO_HWM_EN
    logic [ADDR_W:0] hwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  hwm_q <= '0;
        else if (bus.clr)         hwm_q <= '0;
        else if (count_n > hwm_q) hwm_q <= count_n;
    end

    assign bus.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed plan steps plus random traffic against a queue model.
module tb_lifo_stack;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 2**ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lifo_stack_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    lifo_stack #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_dv, m_ovf, m_unf;
    int unsigned       m_hwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_hwm  = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},      32'(bus.count),      32'(q.size()));
        check({tag, ".full"},       32'(bus.full),       32'(q.size() == DEPTH));
        check({tag, ".empty"},      32'(bus.empty),      32'(q.size() == 0));
        check({tag, ".dout"},       32'(bus.dout),       32'(m_dout));
        check({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_dv));
        check({tag, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
        check({tag, ".underflow"},  32'(bus.underflow),  32'(m_unf));
`ifdef LIFO_HWM_EN
        check({tag, ".hwm"},        32'(bus.hwm),        32'(m_hwm));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check just after the edge.
    task automatic step(input string tag, input logic push, input logic pop,
                        input logic clr, input logic [DATA_W-1:0] din);
        bus.push = push;
        bus.pop  = pop;
        bus.clr  = clr;
        bus.din  = din;
        @(posedge clk);
        m_dv = 1'b0;
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_hwm = 0;
        end else if (push && !pop) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(din);
        end else if (pop && !push) begin
            if (q.size() == 0) m_unf = 1'b1;
            else begin
                m_dout = q.pop_back();
                m_dv   = 1'b1;
            end
        end else if (push && pop) begin
            m_dv = 1'b1;
            if (q.size() == 0) m_dout = din;
            else begin
                m_dout = q[q.size()-1];
                q[q.size()-1] = din;
            end
        end
        if (!clr && q.size() > m_hwm) m_hwm = q.size();
        #1;
        check_all(tag);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.clr  = 1'b0;
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.clr  = 1'b0;
        bus.din  = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        step("push11", 1, 0, 0, 8'h11);
        step("push22", 1, 0, 0, 8'h22);
        step("push33", 1, 0, 0, 8'h33);
        check("plan.count3", 32'(bus.count), 32'd3);
        step("pop1", 0, 1, 0, 8'h00);
        check("plan.pop33", 32'(bus.dout), 32'h33);
        step("pop2", 0, 1, 0, 8'h00);
        check("plan.pop22", 32'(bus.dout), 32'h22);
        step("pop3", 0, 1, 0, 8'h00);
        check("plan.pop11", 32'(bus.dout), 32'h11);
        check("plan.empty", 32'(bus.empty), 32'd1);
        step("idle", 0, 0, 0, 8'h00);

        for (int i = 0; i < 5; i++)
            step("fill", 1, 0, 0, 8'(8'h41 + i));
        check("plan.ovf", 32'(bus.overflow), 32'd1);
        check("plan.full_cnt", 32'(bus.count), 32'd4);
        step("top_after_ovf", 0, 1, 0, 8'h00);
        check("plan.top4", 32'(bus.dout), 32'h44);
        step("clr_a", 0, 0, 1, 8'h00);

        step("pop_empty", 0, 1, 0, 8'h00);
        check("plan.unf", 32'(bus.underflow), 32'd1);
        check("plan.unf_dout", 32'(bus.dout), 32'h44);
        step("clr_unf", 0, 0, 1, 8'h00);
        check("plan.unf_clr", 32'(bus.underflow), 32'd0);

        step("pushA0", 1, 0, 0, 8'hA0);
        step("pushB0", 1, 0, 0, 8'hB0);
        step("replace", 1, 1, 0, 8'hC0);
        check("plan.repl_dout", 32'(bus.dout), 32'hB0);
        step("pop_repl", 0, 1, 0, 8'h00);
        check("plan.repl_top", 32'(bus.dout), 32'hC0);
        step("clr_b", 0, 0, 1, 8'h00);

        step("passthru", 1, 1, 0, 8'h5A);
        check("plan.pass_dout", 32'(bus.dout), 32'h5A);
        check("plan.pass_cnt", 32'(bus.count), 32'd0);

        step("hwm_p1", 1, 0, 0, 8'h01);
        step("hwm_p2", 1, 0, 0, 8'h02);
        step("hwm_p3", 1, 0, 0, 8'h03);
        step("hwm_o1", 0, 1, 0, 8'h00);
        step("hwm_o2", 0, 1, 0, 8'h00);
        step("hwm_p4", 1, 0, 0, 8'h04);
`ifdef LIFO_HWM_EN
        check("plan.hwm3", 32'(bus.hwm), 32'd3);
`endif
        step("hwm_clr", 0, 0, 1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic p, o, c;
            r = $urandom_range(0, 99);
            c = (r < 3);
            p = (r >= 3 && r < 55) || (r >= 85);
            o = (r >= 50);
            step("rand", p, o, c, 8'($urandom));
        end

        // Asynchronous reset while a push is being presented.
        step("pre_rst", 1, 0, 0, 8'h77);
        bus.push = 1'b1;
        bus.din  = 8'h78;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        bus.push = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
